// File: rtl/uart_rx_cfg_if.sv
// Serial receive bundle for uart_rx_cfg: the line input plus the received word and status flags.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_RX_Serial;
  logic                 o_RX_DV;
  logic [DATA_BITS-1:0] o_RX_Data;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;

  modport master (
    output i_RX_Serial,
    input  o_RX_DV,
    input  o_RX_Data,
    input  o_Parity_Err,
    input  o_Frame_Err,
    input  o_Break
  );

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV,
    output o_RX_Data,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Break
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted sampling, optional parity, 1/2 stop bits,
// framing-error and line-break detection.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         i_Clock,
  input  logic         i_Rst_n,
  uart_rx_cfg_if.slave rx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_C     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP_C = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_DONE       = 3'd5,
    ST_BREAK_WAIT = 3'd6
  } state_t;

  function automatic logic majority_f(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Odd mode flags an even count of ones over data+parity; even mode flags an odd count.
  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic x;
    x = (^data) ^ pbit;
    if (PARITY_MODE == 32'sd1) begin
      return ~x;
    end else if (PARITY_MODE == 32'sd2) begin
      return x;
    end else begin
      return 1'b0;
    end
  endfunction

  logic                 sync1_r, sync2_r;
  logic [1:0]           hist_r;
  logic                 maj_s;
  logic                 sample_s;
  logic                 break_s;
  state_t               state_r, state_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 stop_low_any_r;
  logic                 stop_low_all_r;
  logic                 rx_dv_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 break_r;

  assign maj_s    = majority_f({hist_r, sync2_r});
  assign sample_s = (cnt_r == LAST_C);
  assign break_s  = (shift_r == '0) && ((PARITY_MODE == 32'sd0) || !par_bit_r)
                    && stop_low_all_r && !maj_s;

  assign rx.o_RX_DV      = rx_dv_r;
  assign rx.o_RX_Data    = rx_data_r;
  assign rx.o_Parity_Err = parity_err_r;
  assign rx.o_Frame_Err  = frame_err_r;
  assign rx.o_Break      = break_r;

  // Line synchronizer and the two-deep history feeding the majority vote.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      hist_r  <= 2'b11;
    end else begin
      sync1_r <= rx.i_RX_Serial;
      sync2_r <= sync1_r;
      hist_r  <= {hist_r[0], sync2_r};
    end
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!sync2_r) state_next_s = ST_START;
        else          state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == HALF_C) state_next_s = maj_s ? ST_IDLE : ST_DATA;
        else                 state_next_s = ST_START;
      end
      ST_DATA: begin
        if (sample_s && (bit_idx_r == LAST_IDX_C))
          state_next_s = (PARITY_MODE != 32'sd0) ? ST_PARITY : ST_STOP;
        else
          state_next_s = ST_DATA;
      end
      ST_PARITY: begin
        if (sample_s) state_next_s = ST_STOP;
        else          state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        if (sample_s && (stop_idx_r == LAST_STOP_C)) state_next_s = ST_DONE;
        else                                         state_next_s = ST_STOP;
      end
      ST_DONE: begin
        if (break_r) state_next_s = ST_BREAK_WAIT;
        else         state_next_s = ST_IDLE;
      end
      ST_BREAK_WAIT: begin
        if (sync2_r) state_next_s = ST_IDLE;
        else         state_next_s = ST_BREAK_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and bit-period counter; the counter restarts on every state change and sample.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      if ((state_next_s != state_r) || sample_s) cnt_r <= '0;
      else                                       cnt_r <= cnt_r + 1'b1;
    end
  end

  // Frame assembly: data shift register, parity bit and stop-bit observations.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bit_idx_r      <= '0;
      stop_idx_r     <= 1'b0;
      shift_r        <= '0;
      par_bit_r      <= 1'b0;
      stop_low_any_r <= 1'b0;
      stop_low_all_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_idx_r      <= '0;
          stop_idx_r     <= 1'b0;
          par_bit_r      <= 1'b0;
          stop_low_any_r <= 1'b0;
          stop_low_all_r <= 1'b1;
        end
        ST_DATA: begin
          if (sample_s) begin
            shift_r   <= {maj_s, shift_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + 1'b1;
          end
        end
        ST_PARITY: begin
          if (sample_s) par_bit_r <= maj_s;
        end
        ST_STOP: begin
          if (sample_s) begin
            stop_idx_r     <= stop_idx_r + 1'b1;
            stop_low_any_r <= stop_low_any_r | ~maj_s;
            stop_low_all_r <= stop_low_all_r & ~maj_s;
          end
        end
        default: begin
          stop_idx_r <= stop_idx_r;
        end
      endcase
    end
  end

  // Result registers load on the last stop sample so they change together with the DV pulse.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_dv_r      <= 1'b0;
      rx_data_r    <= '0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      break_r      <= 1'b0;
    end else begin
      rx_dv_r <= (state_next_s == ST_DONE);
      if ((state_r == ST_STOP) && (state_next_s == ST_DONE)) begin
        rx_data_r    <= shift_r;
        parity_err_r <= parity_err_f(shift_r, par_bit_r);
        frame_err_r  <= stop_low_any_r | ~maj_s;
        break_r      <= break_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized self-checking bench for uart_rx_cfg: three configurations against a frame-level model.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n;
  logic [2:0] line_r;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] q2[$];
  logic [11:0] last_v [3];
  logic        prev_dv [3];
  bit          chk_en = 1'b0;
  bit          lat_req = 1'b0;
  bit          lat_armed = 1'b0;
  int          lat_start = 0;

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();
  assign if0.i_RX_Serial = line_r[0];
  assign if1.i_RX_Serial = line_r[1];
  assign if2.i_RX_Serial = line_r[2];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    u0 (.i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .rx(if0.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1))
    u1 (.i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .rx(if1.slave));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2))
    u2 (.i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .rx(if2.slave));

  function automatic int cfg_db(input int id);
    return (id == 1) ? 7 : 8;
  endfunction
  function automatic int cfg_pm(input int id);
    return (id == 1) ? 2 : ((id == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_sb(input int id);
    return (id == 2) ? 2 : 1;
  endfunction

  // Observed outputs packed as {data[8:0], parity_err, frame_err, break}.
  function automatic logic [11:0] obs(input int id);
    case (id)
      0: return {9'(if0.o_RX_Data), if0.o_Parity_Err, if0.o_Frame_Err, if0.o_Break};
      1: return {9'(if1.o_RX_Data), if1.o_Parity_Err, if1.o_Frame_Err, if1.o_Break};
      default: return {9'(if2.o_RX_Data), if2.o_Parity_Err, if2.o_Frame_Err, if2.o_Break};
    endcase
  endfunction
  function automatic logic obs_dv(input int id);
    case (id)
      0: return if0.o_RX_DV;
      1: return if1.o_RX_DV;
      default: return if2.o_RX_DV;
    endcase
  endfunction

  task automatic push_exp(input int id, input logic [11:0] v);
    case (id)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic lit(input string nm, input logic [11:0] got, input logic [11:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp_v);
    end
  endtask

  task automatic check_out(input int id, input logic dv, input logic [11:0] got);
    logic [11:0] exp_v;
    int qn;
    int lat;
    if (dv) begin
      n_checks++;
      if (prev_dv[id]) begin
        n_errors++;
        $display("FAIL dv_pulse inst%0d: DV high two cycles in a row, required one", id);
      end
      qn = (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q2.size());
      n_checks++;
      if (qn == 0) begin
        n_errors++;
        $display("FAIL unexpected_dv inst%0d: got frame %h required no DV", id, got);
      end else begin
        case (id)
          0: exp_v = q0.pop_front();
          1: exp_v = q1.pop_front();
          default: exp_v = q2.pop_front();
        endcase
        if (got !== exp_v) begin
          n_errors++;
          $display("FAIL frame inst%0d: got %h required %h", id, got, exp_v);
        end
      end
      if (id == 0 && lat_armed) begin
        lat_armed = 1'b0;
        lat = cyc - lat_start;
        n_checks++;
        if (lat < 152 || lat > 154) begin
          n_errors++;
          $display("FAIL latency: got %0d cycles required 152..154", lat);
        end
      end
      last_v[id] = got;
    end else begin
      n_checks++;
      if (got !== last_v[id]) begin
        n_errors++;
        $display("FAIL hold inst%0d: got %h required %h", id, got, last_v[id]);
        last_v[id] = got;
      end
    end
    prev_dv[id] = dv;
  endtask

  // Every cycle out of reset: DV must match a modelled frame, otherwise outputs must hold.
  initial begin
    forever begin
      @(posedge i_Clock);
      #1;
      if (i_Rst_n === 1'b1 && chk_en) begin
        for (int id = 0; id < 3; id++) check_out(id, obs_dv(id), obs(id));
      end else begin
        for (int id = 0; id < 3; id++) prev_dv[id] = 1'b0;
      end
    end
  end

  task automatic rest(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clock);
      line_r[id] = 1'b1;
    end
  endtask

  // Drives one frame; pforce < 0 sends the correct parity bit. Spike inverts one cycle mid-bit.
  task automatic send_frame(input int id, input logic [8:0] data, input int pforce,
                            input logic [1:0] stops, input int spike_bit, input bit expect_dv);
    logic [15:0] bits;
    logic [8:0]  d;
    logic        pbit, pe, fe, brk, all_low;
    int n, db, pm, sb, ones;
    db = cfg_db(id);
    pm = cfg_pm(id);
    sb = cfg_sb(id);
    d = '0;
    for (int i = 0; i < db; i++) d[i] = data[i];
    ones = $countones(d);
    if (pforce >= 0)  pbit = pforce[0];
    else if (pm == 1) pbit = (ones % 2 == 0);
    else              pbit = (ones % 2 == 1);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < db; i++) begin bits[n] = d[i]; n++; end
    if (pm != 0) begin bits[n] = pbit; n++; end
    fe = 1'b0;
    all_low = 1'b1;
    for (int s = 0; s < sb; s++) begin
      bits[n] = stops[s];
      n++;
      if (!stops[s]) fe = 1'b1;
      else           all_low = 1'b0;
    end
    if (pm == 0)      pe = 1'b0;
    else if (pm == 1) pe = ((ones + int'(pbit)) % 2 == 0);
    else              pe = ((ones + int'(pbit)) % 2 == 1);
    brk = (d == 9'd0) && (pm == 0 || !pbit) && all_low;
    if (expect_dv) push_exp(id, {d, pe, fe, brk});
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge i_Clock);
        if (b == 0 && c == 0 && lat_req) begin
          lat_start = cyc + 1;
          lat_armed = 1'b1;
        end
        line_r[id] = (b == spike_bit && c == 7) ? ~bits[b] : bits[b];
      end
    end
  endtask

  initial begin
    int id, gap, pf, spk;
    logic [1:0] st;
    logic [8:0] dat;
    line_r  = 3'b111;
    i_Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin last_v[i] = '0; prev_dv[i] = 1'b0; end
    #2 i_Rst_n = 1'b0;
    repeat (3) @(negedge i_Clock);
    for (int i = 0; i < 3; i++) lit("reset_outputs", {obs(i)[11:1], obs_dv(i)}, 12'h000);
    i_Rst_n = 1'b1;
    chk_en  = 1'b1;
    rest(0, 4);

    // 8N1 0xA5 with latency window
    lat_req = 1'b1;
    send_frame(0, 9'h0A5, -1, 2'b11, -1, 1'b1);
    lat_req = 1'b0;
    rest(0, 2 * CPB);
    lit("a5_frame", obs(0), {9'h0A5, 3'b000});

    // 7E1: correct then wrong parity bit for 0x55
    send_frame(1, 9'h055, 0, 2'b11, -1, 1'b1);
    rest(1, 2 * CPB);
    lit("e7_parity_ok", obs(1), {9'h055, 3'b000});
    send_frame(1, 9'h055, 1, 2'b11, -1, 1'b1);
    rest(1, 2 * CPB);
    lit("e7_parity_bad", obs(1), {9'h055, 3'b100});

    // Start glitch, then a valid 0x3C
    for (int i = 0; i < 3; i++) begin @(negedge i_Clock); line_r[0] = 1'b0; end
    rest(0, 3 * CPB);
    send_frame(0, 9'h03C, -1, 2'b11, -1, 1'b1);
    rest(0, 2 * CPB);
    lit("glitch_then_3c", obs(0), {9'h03C, 3'b000});

    // Two stop bits, second low, with a data-bit spike
    send_frame(2, 9'h0B2, -1, 2'b01, 3, 1'b1);
    rest(2, 2 * CPB);
    lit("stop2_low", obs(2), {9'h0B2, 3'b010});

    // Line break for 20 bit periods, then 0x81
    push_exp(0, {9'h000, 3'b011});
    for (int i = 0; i < 20 * CPB; i++) begin @(negedge i_Clock); line_r[0] = 1'b0; end
    lit("break_flags", obs(0), {9'h000, 3'b011});
    rest(0, 2 * CPB);
    send_frame(0, 9'h081, -1, 2'b11, -1, 1'b1);
    rest(0, 2 * CPB);
    lit("after_break_81", obs(0), {9'h081, 3'b000});

    // Reset mid-DATA, then back-to-back 0xFF and 0x00
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge i_Clock);
      line_r[0] = (i < CPB) ? 1'b0 : ((i < 2 * CPB) ? 1'b1 : 1'b0);
    end
    i_Rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) lit("reset_mid_frame", {obs(i)[11:1], obs_dv(i)}, 12'h000);
    for (int i = 0; i < 3; i++) last_v[i] = '0;
    rest(0, 3);
    i_Rst_n = 1'b1;
    rest(0, 2);
    send_frame(0, 9'h0FF, -1, 2'b11, -1, 1'b1);
    send_frame(0, 9'h000, -1, 2'b11, -1, 1'b1);
    rest(0, 2 * CPB);
    lit("b2b_last", obs(0), {9'h000, 3'b000});

    // Randomized frames across all three configurations
    for (int k = 0; k < 60; k++) begin
      id  = int'($urandom_range(0, 2));
      dat = 9'($urandom);
      pf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      st  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      spk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, cfg_db(id))) : -1;
      send_frame(id, dat, pf, st, spk, 1'b1);
      gap = ((cfg_sb(id) == 2) ? !st[1] : !st[0]) ? CPB : 1;
      rest(id, gap + int'($urandom_range(0, 2 * CPB)));
    end

    rest(0, 2 * CPB);
    for (int w = 0; w < 4000 && (q0.size() + q1.size() + q2.size()) != 0; w++)
      @(negedge i_Clock);
    lit("drain_inst0", 12'(q0.size()), 12'h000);
    lit("drain_inst1", 12'(q1.size()), 12'h000);
    lit("drain_inst2", 12'(q2.size()), 12'h000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87: clock cycles per bit period; legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: 1 or 2 stop bits checked.
REQ-005 Port i_Clock  input  1: sole clock; all state updates on its rising edge.
REQ-006 Port i_Rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 Port i_RX_Serial  input  1: asynchronous serial line; idle high.
REQ-008 Port o_RX_DV  output  1: one-cycle pulse marking a completed frame.
REQ-009 Port o_RX_Data  output  DATA_BITS: received data, LSB first on the line.
REQ-010 Port o_Parity_Err  output  1: parity mismatch on last frame; 0 when PARITY_MODE = 0.
REQ-011 Port o_Frame_Err  output  1: a stop bit sampled low on last frame.
REQ-012 Port o_Break  output  1: last frame was all-zero through the stop bits.

Function
REQ-013 i_RX_Serial SHALL pass through a 2-flop synchronizer (reset to 1); all logic uses the synchronized value.
REQ-014 Bit value SHALL be the majority of the 3 most recent synchronized samples at each sample point.
REQ-015 Bit-period counter width SHALL be $clog2(CLKS_PER_BIT); counter resets to 0 on every state change.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT; encoding is free; unused encodings SHALL go to IDLE.
REQ-017 IDLE: synchronized line low -> START, counter 0.
REQ-018 START: at count (CLKS_PER_BIT-1)/2, majority low -> DATA with counter 0; majority high -> IDLE (glitch rejected, no flags changed).
REQ-019 DATA: sample at count CLKS_PER_BIT-1 into bit index 0..DATA_BITS-1; after the last bit -> PARITY if PARITY_MODE != 0, else STOP.
REQ-020 PARITY: sample at count CLKS_PER_BIT-1; error when XOR(data, parity bit) is 0 for odd or 1 for even.
REQ-021 STOP: sample each stop bit at count CLKS_PER_BIT-1; after STOP_BITS samples -> DONE; no wait for the stop-bit end.
REQ-022 DONE (one cycle): o_RX_DV = 1; o_RX_Data, o_Parity_Err, o_Frame_Err, o_Break update in the same cycle.
REQ-023 After DONE: break frame -> BREAK_WAIT, otherwise -> IDLE.
REQ-024 Break frame = all data bits, the parity bit (if present) and every stop bit sampled 0; it also sets o_Frame_Err = 1.
REQ-025 BREAK_WAIT SHALL stay until the synchronized line is high, then go to IDLE; no new start bit is detected while in BREAK_WAIT.
REQ-026 o_RX_Data and all flags SHALL hold from one DONE to the next and are not zeroed between frames.
REQ-027 o_RX_DV SHALL never be high on two consecutive cycles.
REQ-028 A falling edge during STOP or DONE SHALL not be lost: if the line is low on entry to IDLE, START is entered on the next cycle.

Reset
REQ-029 i_Rst_n low SHALL immediately force IDLE, counters 0, synchronizer flops 1, o_RX_DV 0, o_RX_Data 0 and all flags 0.
REQ-030 Reset in any state SHALL abandon the partial frame; no o_RX_DV for it after reset release.
REQ-031 The first frame SHALL be accepted after deassertion once the line has been high for at least 2 cycles.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-032 Defaults 8N1: send 0xA5 -> one o_RX_DV pulse; o_RX_Data = 0xA5; all flags 0; pulse 2+7+8*16+16 cycles after the start edge, ±1.
REQ-033 DATA_BITS=7, even parity: send 0x55 with parity bit 0 -> Parity_Err 0; parity bit 1 -> Parity_Err 1 and data 0x55.
REQ-034 Start glitch: line low for 3 cycles then high -> no o_RX_DV; the next valid 0x3C frame is received correctly.
REQ-035 STOP_BITS=2, second stop bit low -> o_Frame_Err 1, o_Break 0; a one-cycle 0 spike mid-bit is rejected by the majority vote.
REQ-036 Line held low for 20 bit periods -> one o_RX_DV with data 0, o_Break 1, o_Frame_Err 1; no further DV until the line goes high; then 0x81 is received cleanly.
REQ-037 Reset asserted mid-DATA -> outputs 0 in the same cycle; no DV; back-to-back 0xFF, 0x00 frames after release -> two DVs with the correct data.
